// File: rtl/matrix_wb_scheduler.sv
// rtl/matrix_wb_scheduler.sv - matrix-multiply sequencer and register-file write-port arbiter
module matrix_wb_scheduler #(
   parameter int DATA_W  = 8,
   parameter int REG_AW  = 3,
   parameter int NUM_RES = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                        CLK,
   input  logic                        reset,
   input  logic                        mm_start,
   input  logic [REG_AW-1:0]           mm_dest_base,
   input  logic                        pipe_quiet,
   input  logic                        wb_write_pipe,
   input  logic [REG_AW-1:0]           wb_dest_pipe,
   input  logic [DATA_W-1:0]           wb_data_pipe,
   input  logic                        mult_done,
   input  logic [NUM_RES*DATA_W-1:0]   mult_c,
   output logic                        mult_go,
   output logic                        stall_req,
   output logic                        mm_busy,
   output logic                        rf_write,
   output logic [REG_AW-1:0]           rf_dest,
   output logic [DATA_W-1:0]           rf_data,
   output logic                        mm_complete,
   output logic                        err_timeout,
   output logic                        err_overlap
);

   localparam int IDX_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_RES - 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic [DATA_W-1:0] res_buf [NUM_RES];
   logic [IDX_W-1:0]  idx;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [REG_AW-1:0] base;
   logic              grant;
   logic              capture;
   logic              timeout_hit;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      grant       = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      cnt_inc     = cnt + 1'b1;
      mult_go     = 1'b0;
      mm_busy     = 1'b1;
      mm_complete = 1'b0;
      case (state)
         S_IDLE: begin
            mm_busy = 1'b0;
            if (mm_start) state_next = S_LAUNCH;
         end
         S_LAUNCH: begin
            mult_go    = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            // cnt_inc is the number of WAIT cycles spent including this one
            if (mult_done) begin
               capture    = 1'b1;
               state_next = S_DRAIN;
            end else if (cnt_inc == CNT_LIMIT) begin
               timeout_hit = 1'b1;
               state_next  = S_DONE;
            end
         end
         S_DRAIN: begin
            grant = pipe_quiet && !wb_write_pipe;
            if (grant && idx == IDX_LAST) state_next = S_DONE;
         end
         S_DONE: begin
            mm_complete = 1'b1;
            state_next  = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      stall_req = mm_busy;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         base        <= '0;
         idx         <= '0;
         cnt         <= '0;
         err_timeout <= 1'b0;
         err_overlap <= 1'b0;
         for (int k = 0; k < NUM_RES; k++) res_buf[k] <= '0;
      end else begin
         if (state == S_IDLE && mm_start) base <= mm_dest_base;
         if (state == S_LAUNCH)     cnt <= '0;
         else if (state == S_WAIT)  cnt <= cnt_inc;
         if (capture) begin
            idx <= '0;
            for (int k = 0; k < NUM_RES; k++) res_buf[k] <= mult_c[DATA_W*k +: DATA_W];
         end else if (grant) begin
            idx <= idx + 1'b1;
         end
         if (timeout_hit) err_timeout <= 1'b1;
         if (mm_start && state != S_IDLE) err_overlap <= 1'b1;
      end
   end

   // Pipe writeback always wins; reset also silences the pass-through path.
   always_comb begin
      rf_write = 1'b0;
      rf_dest  = '0;
      rf_data  = '0;
      if (wb_write_pipe && reset) begin
         rf_write = 1'b1;
         rf_dest  = wb_dest_pipe;
         rf_data  = wb_data_pipe;
      end else if (grant) begin
         rf_write = 1'b1;
         rf_dest  = base + REG_AW'(idx);
         rf_data  = res_buf[idx];
      end
   end

endmodule

// File: tb/tb_matrix_wb_scheduler.sv
// tb/tb_matrix_wb_scheduler.sv - directed self-checking bench for matrix_wb_scheduler
module tb_matrix_wb_scheduler;

   logic        CLK;
   logic        reset;
   logic        mm_start;
   logic [2:0]  mm_dest_base;
   logic        pipe_quiet;
   logic        wb_write_pipe;
   logic [2:0]  wb_dest_pipe;
   logic [7:0]  wb_data_pipe;
   logic        mult_done;
   logic [31:0] mult_c;
   logic        mult_go;
   logic        stall_req;
   logic        mm_busy;
   logic        rf_write;
   logic [2:0]  rf_dest;
   logic [7:0]  rf_data;
   logic        mm_complete;
   logic        err_timeout;
   logic        err_overlap;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int t0;
   int cmp_cyc;
   int wr_cyc[$];
   int wr_dest[$];
   int wr_data[$];

   matrix_wb_scheduler dut (
      .CLK           (CLK),
      .reset         (reset),
      .mm_start      (mm_start),
      .mm_dest_base  (mm_dest_base),
      .pipe_quiet    (pipe_quiet),
      .wb_write_pipe (wb_write_pipe),
      .wb_dest_pipe  (wb_dest_pipe),
      .wb_data_pipe  (wb_data_pipe),
      .mult_done     (mult_done),
      .mult_c        (mult_c),
      .mult_go       (mult_go),
      .stall_req     (stall_req),
      .mm_busy       (mm_busy),
      .rf_write      (rf_write),
      .rf_dest       (rf_dest),
      .rf_data       (rf_data),
      .mm_complete   (mm_complete),
      .err_timeout   (err_timeout),
      .err_overlap   (err_overlap)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (rf_write) begin
         wr_cyc.push_back(cyc);
         wr_dest.push_back(int'(rf_dest));
         wr_data.push_back(int'(rf_data));
      end
      if (mm_complete) cmp_cyc = cyc;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic clear_log();
      wr_cyc.delete();
      wr_dest.delete();
      wr_data.delete();
      cmp_cyc = -1;
   endtask

   task automatic start_op(input logic [2:0] b);
      clear_log();
      t0 = cyc;
      mm_start = 1'b1;
      mm_dest_base = b;
      tick();
      mm_start = 1'b0;
   endtask

   task automatic give_done(input logic [31:0] v);
      mult_done = 1'b1;
      mult_c = v;
      tick();
      mult_done = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && mm_busy; i++) tick();
      check_eq("idle_bound", mm_busy, 1'b0);
   endtask

   task automatic expect_wr(input string tag, input int i, input int c, input int d, input int v);
      if (i < wr_cyc.size()) begin
         check_eq({tag, "_cyc"}, wr_cyc[i], c);
         check_eq({tag, "_dest"}, wr_dest[i], d);
         check_eq({tag, "_data"}, wr_data[i], v);
      end else begin
         check_eq({tag, "_count"}, wr_cyc.size(), i + 1);
      end
   endtask

   initial begin
      reset = 1'b0;
      mm_start = 1'b0;
      mm_dest_base = '0;
      pipe_quiet = 1'b1;
      wb_write_pipe = 1'b0;
      wb_dest_pipe = '0;
      wb_data_pipe = '0;
      mult_done = 1'b0;
      mult_c = '0;
      cmp_cyc = -1;
      tick(2);
      check_eq("rst_busy", mm_busy, 1'b0);
      check_eq("rst_go", mult_go, 1'b0);
      check_eq("rst_rfw", rf_write, 1'b0);
      check_eq("rst_errs", {err_timeout, err_overlap}, 2'b00);
      reset = 1'b1;
      tick();

      // 1 basic: done 3 cycles after go
      start_op(3'd4);
      check_eq("t1_go", mult_go, 1'b1);
      check_eq("t1_stall", stall_req, 1'b1);
      tick();
      check_eq("t1_go_pulse", mult_go, 1'b0);
      tick(2);
      give_done(32'h44332211);
      wait_idle();
      check_eq("t1_nwr", wr_cyc.size(), 4);
      for (int k = 0; k < 4; k++) expect_wr("t1", k, t0 + 5 + k, 4 + k, 8'h11 * (k + 1));
      check_eq("t1_cmp", cmp_cyc, t0 + 9);

      // 2 contention during idx=1
      start_op(3'd4);
      tick();
      give_done(32'hDDCCBBAA);
      tick();
      wb_write_pipe = 1'b1;
      wb_dest_pipe = 3'd2;
      wb_data_pipe = 8'h5A;
      tick();
      wb_write_pipe = 1'b0;
      wait_idle();
      check_eq("t2_nwr", wr_cyc.size(), 5);
      expect_wr("t2_r4", 0, t0 + 3, 4, 8'hAA);
      expect_wr("t2_pipe", 1, t0 + 4, 2, 8'h5A);
      expect_wr("t2_r5", 2, t0 + 5, 5, 8'hBB);
      expect_wr("t2_r6", 3, t0 + 6, 6, 8'hCC);
      expect_wr("t2_r7", 4, t0 + 7, 7, 8'hDD);
      check_eq("t2_cmp", cmp_cyc, t0 + 8);

      // 3 ordering: pipe not quiet for 3 cycles after capture
      start_op(3'd0);
      tick();
      pipe_quiet = 1'b0;
      give_done(32'h04030201);
      for (int k = 0; k < 3; k++) begin
         check_eq("t3_stall", stall_req, 1'b1);
         check_eq("t3_nowr", rf_write, 1'b0);
         if (k < 2) tick();
      end
      tick();
      pipe_quiet = 1'b1;
      wait_idle();
      check_eq("t3_nwr", wr_cyc.size(), 4);
      for (int k = 0; k < 4; k++) expect_wr("t3", k, t0 + 6 + k, k, k + 1);
      check_eq("t3_cmp", cmp_cyc, t0 + 10);

      // 4a destination wrap
      start_op(3'd6);
      tick();
      give_done(32'h88776655);
      wait_idle();
      expect_wr("t4_r6", 0, t0 + 3, 6, 8'h55);
      expect_wr("t4_r7", 1, t0 + 4, 7, 8'h66);
      expect_wr("t4_r0", 2, t0 + 5, 0, 8'h77);
      expect_wr("t4_r1", 3, t0 + 6, 1, 8'h88);

      // 4b timeout: 64 WAIT cycles (t0+2..t0+65)
      start_op(3'd2);
      tick(64);
      check_eq("t4_pre_to", err_timeout, 1'b0);
      check_eq("t4_pre_busy", mm_busy, 1'b1);
      tick();
      check_eq("t4_to", err_timeout, 1'b1);
      check_eq("t4_to_cmp", mm_complete, 1'b1);
      tick();
      check_eq("t4_to_idle", mm_busy, 1'b0);
      check_eq("t4_to_nwr", wr_cyc.size(), 0);
      check_eq("t4_to_sticky", err_timeout, 1'b1);

      // 5 reset mid-DRAIN after 2 writes
      start_op(3'd1);
      tick();
      give_done(32'h99887766);
      tick(2);
      reset = 1'b0;
      #1;
      check_eq("t5_rfw", rf_write, 1'b0);
      check_eq("t5_busy", {mm_busy, stall_req, mult_go, mm_complete}, 4'b0000);
      check_eq("t5_errs", {err_timeout, err_overlap}, 2'b00);
      tick();
      reset = 1'b1;
      tick(4);
      check_eq("t5_nwr", wr_cyc.size(), 2);
      expect_wr("t5_w1", 1, t0 + 4, 2, 8'h77);
      start_op(3'd3);
      tick();
      give_done(32'h0F0E0D0C);
      wait_idle();
      check_eq("t5_new_nwr", wr_cyc.size(), 4);
      for (int k = 0; k < 4; k++) expect_wr("t5_new", k, t0 + 3 + k, 3 + k, 8'h0C + k);

      // 6 overlap during WAIT
      start_op(3'd2);
      tick();
      mm_start = 1'b1;
      mm_dest_base = 3'd5;
      tick();
      mm_start = 1'b0;
      check_eq("t6_ovl", err_overlap, 1'b1);
      give_done(32'h0D0C0B0A);
      wait_idle();
      check_eq("t6_nwr", wr_cyc.size(), 4);
      for (int k = 0; k < 4; k++) expect_wr("t6", k, t0 + 4 + k, 2 + k, 8'h0A + k);
      check_eq("t6_cmp", cmp_cyc, t0 + 8);
      tick(3);
      check_eq("t6_no_relaunch", mm_busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
